// File: rtl/i2c_lcd_target.sv
// i2c_lcd_target: I2C target that emulates a PCF8574-style 8-bit port expander.
// Answers one 7-bit address. Written bytes are latched onto port_out.
// Reads return a coherent snapshot of port_in. SCL is never driven or stretched.
// SDA is driven only through sda_oe (1 = pull low at the open-drain pad).
module i2c_lcd_target #(
  parameter logic [6:0] ADDR       = 7'h27,
  parameter logic [7:0] PORT_RESET = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  input  logic [7:0] port_in,
  output logic [7:0] port_out,
  output logic       wr_strobe,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_ACK,
    S_IGNORE
  } state_t;

  // Synchronizer and history flops. They carry no control state, so they are not reset.
  logic scl_s1_q, scl_s2_q, scl_h_q;
  logic sda_s1_q, sda_s2_q, sda_h_q;

  // Registered bus events, one cycle wide, seen by the FSM.
  logic rise_q, fall_q, start_q, stop_q;
  logic sda_bit_q;

  // Combinational event detection on the synchronized signals.
  logic rise_d, fall_d, start_d, stop_d;

  // FSM and output registers.
  state_t     state_q;
  logic [3:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic       rw_q;
  logic       sda_oe_q;
  logic [7:0] port_out_q;
  logic       wr_strobe_q;
  logic       busy_q;

  // Two-flop synchronizers plus one history flop per line, for edge detection.
  always_ff @(posedge clk) begin
    scl_s1_q <= scl_i;
    scl_s2_q <= scl_s1_q;
    scl_h_q  <= scl_s2_q;
    sda_s1_q <= sda_i;
    sda_s2_q <= sda_s1_q;
    sda_h_q  <= sda_s2_q;
  end

  // START/STOP need SCL high in both the current and the previous sample, so
  // that an SDA change right at an SCL edge is never taken as a condition.
  always_comb begin
    rise_d  = scl_s2_q & ~scl_h_q;
    fall_d  = ~scl_s2_q & scl_h_q;
    start_d = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
    stop_d  = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
  end

  // Register the detected events so that the FSM acts on a clean one-cycle pulse.
  // The data bit is captured alongside the rising edge it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      start_q <= start_d;
      stop_q  <= stop_d;
    end
    sda_bit_q <= sda_s2_q;
  end

  // Protocol FSM with registered outputs. STOP is checked before START, so STOP
  // wins when both appear in the same cycle. Either condition aborts a partial byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      port_out_q  <= PORT_RESET;
      wr_strobe_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      wr_strobe_q <= 1'b0;
      if (stop_q) begin
        state_q   <= S_IDLE;
        bit_cnt_q <= 4'd0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
      end else if (start_q) begin
        state_q   <= S_ADDR;
        bit_cnt_q <= 4'd0;
        shift_q   <= 8'h00;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            sda_oe_q <= 1'b0;
          end

          // Shift in address + R/W. The decision is made on the falling edge
          // after bit 8, which is also the moment the ACK must be driven.
          S_ADDR: begin
            if (rise_q && bit_cnt_q < 4'd8) begin
              shift_q   <= {shift_q[6:0], sda_bit_q};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (fall_q && bit_cnt_q == 4'd8) begin
              bit_cnt_q <= 4'd0;
              if (shift_q[7:1] == ADDR) begin
                state_q  <= S_ADDR_ACK;
                sda_oe_q <= 1'b1;
                busy_q   <= 1'b1;
                rw_q     <= shift_q[0];
              end else begin
                state_q  <= S_IGNORE;
                sda_oe_q <= 1'b0;
              end
            end
          end

          // End of the address ACK clock. A read snapshots port_in here and
          // puts its MSB on the bus immediately.
          S_ADDR_ACK: begin
            if (fall_q) begin
              if (rw_q) begin
                shift_q   <= {port_in[6:0], 1'b0};
                sda_oe_q  <= ~port_in[7];
                bit_cnt_q <= 4'd1;
                state_q   <= S_RD_DATA;
              end else begin
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= 4'd0;
                state_q   <= S_WR_DATA;
              end
            end
          end

          // Shift in a data byte; commit it and ACK on the falling edge after bit 8.
          S_WR_DATA: begin
            if (rise_q && bit_cnt_q < 4'd8) begin
              shift_q   <= {shift_q[6:0], sda_bit_q};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (fall_q && bit_cnt_q == 4'd8) begin
              port_out_q  <= shift_q;
              wr_strobe_q <= 1'b1;
              sda_oe_q    <= 1'b1;
              bit_cnt_q   <= 4'd0;
              state_q     <= S_WR_ACK;
            end
          end

          S_WR_ACK: begin
            if (fall_q) begin
              sda_oe_q <= 1'b0;
              state_q  <= S_WR_DATA;
            end
          end

          // bit_cnt_q counts bits already placed on SDA. The MSB went out on entry.
          S_RD_DATA: begin
            if (fall_q) begin
              if (bit_cnt_q == 4'd8) begin
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= 4'd0;
                state_q   <= S_RD_ACK;
              end else begin
                sda_oe_q  <= ~shift_q[7];
                shift_q   <= {shift_q[6:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end

          // A NACK on the 9th rising edge ends the read. Otherwise the next
          // falling edge starts another byte from a fresh port_in snapshot.
          S_RD_ACK: begin
            if (rise_q && sda_bit_q) begin
              state_q <= S_IGNORE;
              busy_q  <= 1'b0;
            end else if (fall_q) begin
              shift_q   <= {port_in[6:0], 1'b0};
              sda_oe_q  <= ~port_in[7];
              bit_cnt_q <= 4'd1;
              state_q   <= S_RD_DATA;
            end
          end

          S_IGNORE: begin
            sda_oe_q <= 1'b0;
          end

          default: begin
            state_q  <= S_IDLE;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda_oe    = sda_oe_q;
  assign port_out  = port_out_q;
  assign wr_strobe = wr_strobe_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_lcd_target.sv
// tb_i2c_lcd_target: bit-banged I2C master driving i2c_lcd_target over a
// wired-AND SDA line. A table of write transactions is applied in a loop.
// Hand-written sequences cover reads, multi-byte writes, aborts and reset.
module tb_i2c_lcd_target;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m, sda_m;
  logic       sda_line;
  logic       sda_oe, wr_strobe, busy;
  logic [7:0] port_in, port_out;

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_lcd_target #(.ADDR(7'h27), .PORT_RESET(8'hFF)) dut (
    .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_line), .sda_oe(sda_oe),
    .port_in(port_in), .port_out(port_out), .wr_strobe(wr_strobe), .busy(busy)
  );

  int total_cnt = 0;
  int pass_cnt  = 0;

  // Bus monitor: records every committed byte and counts activity.
  int         strobe_cnt = 0;
  int         oe_cnt     = 0;
  int         dbl_cnt    = 0;
  logic       prev_strobe = 1'b0;
  logic [7:0] obs [64];

  always @(negedge clk) begin
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    if (wr_strobe) begin
      obs[strobe_cnt % 64] <= port_out;
      strobe_cnt <= strobe_cnt + 1;
    end
    if (wr_strobe && prev_strobe) dbl_cnt <= dbl_cnt + 1;
    prev_strobe <= wr_strobe;
  end

  // Scoreboards: expected committed bytes and expected read bytes.
  logic [7:0] wexp_q[$];
  logic [7:0] rexp_q[$];
  int         rd_idx = 0;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       aack;
    logic [7:0] exp_port;
  } wvec_t;

  wvec_t vec [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SCL period starting and ending with SCL low; samples SDA mid-high.
  task automatic bit_xfer(input logic drv, output logic seen, output logic oe_seen);
    sda_m = drv;
    cyc(8);
    scl_m = 1'b1;
    cyc(8);
    seen    = sda_line;
    oe_seen = sda_oe;
    cyc(8);
    scl_m = 1'b0;
    cyc(8);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    cyc(8);
    scl_m = 1'b1;
    cyc(8);
    sda_m = 1'b0;
    cyc(8);
    scl_m = 1'b0;
    cyc(8);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    cyc(8);
    scl_m = 1'b1;
    cyc(8);
    sda_m = 1'b1;
    cyc(16);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic s, o;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], s, o);
    bit_xfer(1'b1, s, o);
    ack = ~s;
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] b, output logic oe9);
    logic s, o;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s, o);
      b[i] = s;
    end
    bit_xfer(~mack, s, oe9);
  endtask

  task automatic half_byte(input logic [3:0] nib);
    logic s, o;
    for (int i = 3; i >= 0; i--) bit_xfer(nib[i], s, o);
  endtask

  // Compare committed bytes seen by the monitor against the expectation queue.
  task automatic drain(input string name);
    int n;
    n = strobe_cnt - rd_idx;
    chk({name, "_strobe_count"}, n, wexp_q.size());
    while (rd_idx < strobe_cnt && wexp_q.size() > 0) begin
      chk({name, "_wr_byte"}, obs[rd_idx % 64], wexp_q.pop_front());
      rd_idx++;
    end
    rd_idx = strobe_cnt;
    wexp_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic       a, o9;
    logic [7:0] b;
    int         oe0;

    vec[0] = '{8'h7E, 8'h55, 1'b0, 8'hFF};
    vec[1] = '{8'h4E, 8'h08, 1'b1, 8'h08};
    vec[2] = '{8'h00, 8'h12, 1'b0, 8'h08};
    vec[3] = '{8'h4C, 8'h33, 1'b0, 8'h08};
    vec[4] = '{8'h4E, 8'hA5, 1'b1, 8'hA5};
    vec[5] = '{8'h4E, 8'h00, 1'b1, 8'h00};
    vec[6] = '{8'h4E, 8'hFF, 1'b1, 8'hFF};

    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; port_in = 8'h00;
    cyc(5);
    rst = 1'b0;
    cyc(10);
    chk("reset_sda_oe", sda_oe, 1'b0);
    chk("reset_port_out", port_out, 8'hFF);
    chk("reset_wr_strobe", wr_strobe, 1'b0);
    chk("reset_busy", busy, 1'b0);

    // Table of single-byte write transactions.
    for (int i = 0; i < 7; i++) begin
      oe0 = oe_cnt;
      i2c_start();
      wr_byte(vec[i].addr, a);
      chk($sformatf("v%0d_addr_ack", i), a, vec[i].aack);
      chk($sformatf("v%0d_busy", i), busy, vec[i].aack);
      if (vec[i].aack) wexp_q.push_back(vec[i].data);
      wr_byte(vec[i].data, a);
      chk($sformatf("v%0d_data_ack", i), a, vec[i].aack);
      i2c_stop();
      chk($sformatf("v%0d_port_out", i), port_out, vec[i].exp_port);
      chk($sformatf("v%0d_busy_stop", i), busy, 1'b0);
      drain($sformatf("v%0d", i));
      if (!vec[i].aack) chk($sformatf("v%0d_sda_quiet", i), oe_cnt - oe0, 0);
    end

    // Read, master NACKs.
    port_in = 8'hA5;
    rexp_q.push_back(8'hA5);
    i2c_start();
    wr_byte(8'h4F, a);
    chk("rd1_addr_ack", a, 1'b1);
    chk("rd1_busy", busy, 1'b1);
    rd_byte(1'b0, b, o9);
    chk("rd1_byte", b, rexp_q.pop_front());
    chk("rd1_oe_9th", o9, 1'b0);
    chk("rd1_busy_nack", busy, 1'b0);
    oe0 = oe_cnt;
    rd_byte(1'b0, b, o9);
    chk("rd1_ignore_quiet", oe_cnt - oe0, 0);
    i2c_stop();
    chk("rd1_busy_stop", busy, 1'b0);

    // Read two bytes: ACK the first, NACK the second; port_in changes in between.
    port_in = 8'h3C;
    rexp_q.push_back(8'h3C);
    i2c_start();
    wr_byte(8'h4F, a);
    chk("rd2_addr_ack", a, 1'b1);
    port_in = 8'hC3;
    rexp_q.push_back(8'hC3);
    rd_byte(1'b1, b, o9);
    chk("rd2_byte0", b, rexp_q.pop_front());
    chk("rd2_oe_9th_ack", o9, 1'b0);
    rd_byte(1'b0, b, o9);
    chk("rd2_byte1", b, rexp_q.pop_front());
    chk("rd2_busy_nack", busy, 1'b0);
    i2c_stop();

    // Three data bytes in one write transfer.
    i2c_start();
    wr_byte(8'h4E, a);
    chk("mw_addr_ack", a, 1'b1);
    wexp_q.push_back(8'h01); wr_byte(8'h01, a); chk("mw_ack0", a, 1'b1);
    wexp_q.push_back(8'h02); wr_byte(8'h02, a); chk("mw_ack1", a, 1'b1);
    wexp_q.push_back(8'h0C); wr_byte(8'h0C, a); chk("mw_ack2", a, 1'b1);
    i2c_stop();
    chk("mw_port_out", port_out, 8'h0C);
    drain("mw");

    // STOP after 4 data bits discards the partial byte.
    i2c_start();
    wr_byte(8'h4E, a);
    half_byte(4'h9);
    i2c_stop();
    chk("abort_port_out", port_out, 8'h0C);
    chk("abort_sda_oe", sda_oe, 1'b0);
    chk("abort_busy", busy, 1'b0);
    drain("abort");

    // Repeated START in the middle of a byte, then a full write.
    i2c_start();
    wr_byte(8'h4E, a);
    half_byte(4'h6);
    i2c_start();
    wr_byte(8'h4E, a);
    chk("rs_addr_ack", a, 1'b1);
    wexp_q.push_back(8'h3A);
    wr_byte(8'h3A, a);
    chk("rs_data_ack", a, 1'b1);
    i2c_stop();
    chk("rs_port_out", port_out, 8'h3A);
    drain("rs");

    // Reset in the middle of a byte, then a full write.
    i2c_start();
    wr_byte(8'h4E, a);
    half_byte(4'h5);
    rst = 1'b1;
    cyc(2);
    chk("rst_port_out", port_out, 8'hFF);
    chk("rst_sda_oe", sda_oe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    cyc(4);
    i2c_stop();
    i2c_start();
    wr_byte(8'h4E, a);
    chk("post_rst_addr_ack", a, 1'b1);
    wexp_q.push_back(8'h77);
    wr_byte(8'h77, a);
    chk("post_rst_data_ack", a, 1'b1);
    i2c_stop();
    chk("post_rst_port_out", port_out, 8'h77);
    drain("post_rst");

    chk("strobe_width", dbl_cnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/i2c_lcd_target.md
# i2c_lcd_target

I2C target (responder) that emulates the PCF8574-style 8-bit port expander on the LCD backpack. It answers the address the LCD master drives and latches written bytes onto a parallel port. It returns a parallel input port on reads. It sits on the same SCL/SDA pair as the I2C master, either as the on-board stand-in for the LCD backpack or as a loop-back target for bring-up and simulation.

## Interface
- `ADDR`, 7'h27, 7-bit target address matched against the first byte.
- `PORT_RESET`, 8'hFF, value of `port_out` after reset (expander powers up with all pins high).
- `clk` input 1: system clock; all logic on rising edge; one clock domain.
- `rst` input 1: synchronous, active-high reset.
- `scl_i` input 1: raw SCL from pad; asynchronous.
- `sda_i` input 1: raw SDA from pad; asynchronous.
- `sda_oe` output 1: 1 pulls SDA low at the open-drain pad; 0 releases the line.
- `port_in` input 8: parallel input returned on reads.
- `port_out` output 8: parallel output register, updated by written bytes.
- `wr_strobe` output 1: one-cycle pulse when `port_out` takes a new byte.
- `busy` output 1: high from an address match until STOP, repeated START or NACK termination.

## Operation
- SCL and SDA each pass through a 2-flop synchronizer and one history flop. The block acts only on edges of the synchronized signals.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
- The block never drives SCL and does no clock stretching.
- Data bits are sampled on SCL rising edges, MSB first. `sda_oe` changes only in the cycle after an SCL falling edge is detected.
- State machine states: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- IDLE -> ADDR on START. From any state, START clears the bit counter and goes to ADDR (repeated START). From any state, STOP goes to IDLE with `sda_oe`=0.
- ADDR: shift 8 bits.
  - Upper 7 bits == `ADDR` -> ADDR_ACK with `busy`=1; the R/W bit picks the data phase.
  - Mismatch -> IGNORE with no ACK and `sda_oe`=0. General call (0x00) is not supported and is treated as a mismatch.
- ADDR_ACK: assert `sda_oe` from the falling edge after bit 8 until the falling edge after bit 9.
  - Write -> WR_DATA, `sda_oe` released.
  - Read -> capture `port_in` in the same cycle, drive the MSB (`sda_oe`=~bit7) and go to RD_DATA.
- WR_DATA: shift 8 bits. On the falling edge after bit 8: `port_out` <= shifted byte, `wr_strobe`=1 for exactly one cycle, `sda_oe`=1 (ACK), go to WR_ACK.
- WR_ACK: on the next falling edge release `sda_oe` and return to WR_DATA. Every byte is ACKed; there is no upper limit on bytes per transfer.
- RD_DATA: on each falling edge shift out the next bit (`sda_oe`=~bit). After 8 bits, release `sda_oe` and go to RD_ACK.
- RD_ACK: sample SDA on the 9th rising edge.
  - Low (master ACK) -> on the falling edge recapture `port_in`, drive its MSB and go to RD_DATA.
  - High (NACK) -> IGNORE with `busy`=0.
- IGNORE: `sda_oe`=0. Wait for START or STOP.
- A STOP or START in the middle of a byte discards the partial byte and leaves `port_out` unchanged.

## Timing
- Reset values: `sda_oe`=0, `port_out`=`PORT_RESET`, `wr_strobe`=0, `busy`=0, state IDLE, bit counter 0, shift register 0.
- Reset overrides everything in the same cycle, including in the middle of a transfer.
- Pad-to-edge-detect latency: 3 `clk` cycles. `sda_oe` responds 1 cycle after the detected SCL falling edge, i.e. 4 cycles after the pad edge.
- Requirement on `clk`: SCL high and low phases must each be ≥ 6 `clk` cycles, and SDA setup/hold around SCL edges must be ≥ 3 cycles. At 100 kHz SCL, 50 MHz `clk` meets this with wide margin.
- `port_out` and `wr_strobe` change in the same cycle. `port_in` is sampled in a single cycle per byte, so the 8 bits returned are always coherent.
- If a START and a STOP condition are detected in the same cycle (glitch), STOP wins.

## Test plan
- Write 0x4E (0x27+W), then data 0x08, then STOP -> ACK low on both 9th clocks; `port_out`=0x08; exactly one `wr_strobe` pulse; `busy` low after STOP.
- Address 0x7E (0x3F+W), then data 0x55 -> SDA never pulled low; `port_out` stays 0xFF; no `wr_strobe`.
- Read 0x4F with `port_in`=0xA5, master NACKs -> SDA carries 1,0,1,0,0,1,0,1; `sda_oe` is 0 on the 9th clock; state IGNORE, then IDLE after STOP.
- Read 0x4F, master ACKs the first byte (`port_in`=0x3C), then `port_in` changes to 0xC3 and the master NACKs the second byte -> bytes 0x3C then 0xC3 on SDA.
- Write 0x4E, then 0x01, 0x02, 0x0C in one transfer -> three `wr_strobe` pulses; `port_out` ends at 0x0C.
- STOP after 4 data bits, and separately `rst` in the middle of a byte -> `port_out` unchanged (respectively 0xFF); `sda_oe`=0; a following full write of 0x4E then 0x77 succeeds.
